// File: rtl/div_iter_if.sv
// Operand and result channels between the core and the iterative divider.
// The core side is the master; the divider responds on the slave modport.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   s_axis_divisor_tdata;
    logic               s_axis_divisor_tvalid;
    logic [WIDTH-1:0]   s_axis_dividend_tdata;
    logic               s_axis_dividend_tvalid;
    logic [2*WIDTH-1:0] m_axis_dout_tdata;
    logic               m_axis_dout_tvalid;
    logic               busy;

    modport master (
        output s_axis_divisor_tdata,
        output s_axis_divisor_tvalid,
        output s_axis_dividend_tdata,
        output s_axis_dividend_tvalid,
        input  m_axis_dout_tdata,
        input  m_axis_dout_tvalid,
        input  busy
    );

    modport slave (
        input  s_axis_divisor_tdata,
        input  s_axis_divisor_tvalid,
        input  s_axis_dividend_tdata,
        input  s_axis_dividend_tvalid,
        output m_axis_dout_tdata,
        output m_axis_dout_tvalid,
        output busy
    );
endinterface

// File: rtl/div_iter.sv
// Behavioural radix-2 restoring divider standing in for the vendor divider IP.
// Result beat packs {quotient, remainder}; divide-by-zero follows RISC-V rules.
module div_iter #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      aclken,
    div_iter_if.slave dif
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]         state_reg;
    logic [CW-1:0]      count_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quo_reg;
    logic [WIDTH-1:0]   dvs_reg;
    logic [WIDTH-1:0]   dvd_raw_reg;
    logic               dvz_reg;
    logic               qsign_reg;
    logic               rsign_reg;
    logic [2*WIDTH-1:0] dout_reg;
    logic               tvalid_reg;

    logic               accept;
    logic               dvd_neg;
    logic               dvs_neg;
    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    assign accept  = (state_reg == ST_IDLE) && dif.s_axis_divisor_tvalid
                     && dif.s_axis_dividend_tvalid;
    assign dvd_neg = SIGNED && dif.s_axis_dividend_tdata[WIDTH-1];
    assign dvs_neg = SIGNED && dif.s_axis_divisor_tdata[WIDTH-1];
    assign dvd_mag = dvd_neg ? (~dif.s_axis_dividend_tdata + 1'b1) : dif.s_axis_dividend_tdata;
    assign dvs_mag = dvs_neg ? (~dif.s_axis_divisor_tdata + 1'b1) : dif.s_axis_divisor_tdata;

    // The WIDTH+1-bit partial remainder exists only as shifted/trial; since the
    // stored remainder is always below the divisor, trial's MSB is its sign.
    assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_reg};
    assign q_bit    = ~trial[WIDTH];
    assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo_reg[WIDTH-2:0], q_bit};

    assign q_fix = dvz_reg ? {WIDTH{1'b1}}
                 : (qsign_reg ? (~quo_reg + 1'b1) : quo_reg);
    assign r_fix = dvz_reg ? dvd_raw_reg
                 : (rsign_reg ? (~rem_reg + 1'b1) : rem_reg);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            dvd_raw_reg <= '0;
            dvz_reg     <= 1'b0;
            qsign_reg   <= 1'b0;
            rsign_reg   <= 1'b0;
            dout_reg    <= '0;
            tvalid_reg  <= 1'b0;
        end else if (aclken) begin
            tvalid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg   <= ST_CALC;
                        count_reg   <= CW'(WIDTH);
                        rem_reg     <= '0;
                        quo_reg     <= dvd_mag;
                        dvs_reg     <= dvs_mag;
                        dvd_raw_reg <= dif.s_axis_dividend_tdata;
                        dvz_reg     <= (dif.s_axis_divisor_tdata == '0);
                        qsign_reg   <= dvd_neg ^ dvs_neg;
                        rsign_reg   <= dvd_neg;
                    end
                end
                ST_CALC: begin
                    rem_reg   <= rem_next;
                    quo_reg   <= quo_next;
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        state_reg <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    dout_reg   <= {q_fix, r_fix};
                    tvalid_reg <= 1'b1;
                    state_reg  <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign dif.m_axis_dout_tdata  = dout_reg;
    assign dif.m_axis_dout_tvalid = tvalid_reg;
    assign dif.busy               = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench driving an unsigned and a signed div_iter with identical stimulus.
// Expected results come from native SV division; one line is printed per result.
module tb_div_iter;
    logic clk = 1'b0;
    logic rst;
    logic aclken;

    always #5 clk = ~clk;

    div_iter_if #(.WIDTH(32)) if_u ();
    div_iter_if #(.WIDTH(32)) if_s ();

    div_iter #(.WIDTH(32), .SIGNED(1'b0)) u_unsigned (
        .clk    (clk),
        .rst    (rst),
        .aclken (aclken),
        .dif    (if_u.slave)
    );

    div_iter #(.WIDTH(32), .SIGNED(1'b1)) u_signed (
        .clk    (clk),
        .rst    (rst),
        .aclken (aclken),
        .dif    (if_s.slave)
    );

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [63:0] exp;
        int          acc;
    } sb_t;

    sb_t         sb_q [2][$];
    int          n_vec = 0;
    int          n_err = 0;
    int          en_edges = 0;
    bit          prev_tv [2];
    int          hi_cnt [2];

    logic [1:0]  tv;
    logic [1:0]  bz;
    logic [63:0] dt [2];

    assign tv    = {if_s.m_axis_dout_tvalid, if_u.m_axis_dout_tvalid};
    assign bz    = {if_s.busy, if_u.busy};
    assign dt[0] = if_u.m_axis_dout_tdata;
    assign dt[1] = if_s.m_axis_dout_tdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return {32'hFFFF_FFFF, a};
        if (!sgn)
            return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {32'h8000_0000, 32'h0};
        return {32'(sa / sb), 32'(sa % sb)};
    endfunction

    function automatic string nm(input int d);
        return (d == 0) ? "u" : "s";
    endfunction

    task automatic set_inputs(input logic [31:0] dvd, input logic [31:0] dvs,
                              input logic vd, input logic vs);
        if_u.s_axis_dividend_tdata  = dvd;
        if_u.s_axis_divisor_tdata   = dvs;
        if_u.s_axis_dividend_tvalid = vd;
        if_u.s_axis_divisor_tvalid  = vs;
        if_s.s_axis_dividend_tdata  = dvd;
        if_s.s_axis_divisor_tdata   = dvs;
        if_s.s_axis_dividend_tvalid = vd;
        if_s.s_axis_divisor_tvalid  = vs;
    endtask

    // Called just after a negedge; the following posedge is the accept edge.
    task automatic issue(input logic [31:0] dvd, input logic [31:0] dvs, input bit accepted);
        sb_t e;
        if (accepted) begin
            for (int d = 0; d < 2; d++) begin
                e.dvd = dvd;
                e.dvs = dvs;
                e.exp = model(dvd, dvs, d == 1);
                e.acc = en_edges + 1;
                sb_q[d].push_back(e);
            end
        end
        set_inputs(dvd, dvs, 1'b1, 1'b1);
        @(negedge clk);
        set_inputs(32'd0, 32'd0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++)
            check({nm(d), "_busy_after_issue"}, 64'(bz[d]), 64'd1);
    endtask

    task automatic run(input logic [31:0] dvd, input logic [31:0] dvs);
        issue(dvd, dvs, 1'b1);
        repeat (36) @(negedge clk);
    endtask

    always @(posedge clk) begin
        bit en_s;
        bit rst_s;
        sb_t e;
        en_s  = aclken;
        rst_s = rst;
        if (!rst_s) begin
            for (int d = 0; d < 2; d++) begin
                sb_q[d].delete();
                prev_tv[d] = 1'b0;
                hi_cnt[d]  = 0;
            end
        end else if (en_s) begin
            en_edges++;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            if (tv[d] && !prev_tv[d]) begin
                if (sb_q[d].size() == 0) begin
                    check({nm(d), "_unexpected_strobe"}, 64'd1, 64'd0);
                end else begin
                    e = sb_q[d].pop_front();
                    $display("[%0t] %s %h / %h -> %h (exp %h)", $time, nm(d), e.dvd, e.dvs, dt[d], e.exp);
                    check({nm(d), "_dout"}, dt[d], e.exp);
                    check({nm(d), "_latency"}, 64'(en_edges - e.acc + 1), 64'd34);
                end
                hi_cnt[d] = 0;
            end
            if (tv[d] && en_s && rst_s)
                hi_cnt[d]++;
            if (!tv[d] && prev_tv[d] && rst_s)
                check({nm(d), "_strobe_len"}, {32'(hi_cnt[d]), 31'd0, en_s}, {32'd1, 32'd1});
            prev_tv[d] = tv[d];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        aclken = 1'b1;
        set_inputs(32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check({nm(d), "_rst_tvalid"}, 64'(tv[d]), 64'd0);
            check({nm(d), "_rst_dout"}, dt[d], 64'd0);
            check({nm(d), "_rst_busy"}, 64'(bz[d]), 64'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        run(32'd100, 32'd7);
        run(32'hFFFF_FFF9, 32'd2);
        run(32'd7, 32'hFFFF_FFFE);
        run(32'hFFFF_FFF9, 32'hFFFF_FFFE);
        run(32'd5, 32'd0);
        run(32'h8000_0000, 32'hFFFF_FFFF);
        run(32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 4; i++)
            run($urandom, $urandom_range(1, 100000));

        // One channel alone must not start an operation.
        set_inputs(32'd11, 32'd3, 1'b1, 1'b0);
        @(negedge clk);
        set_inputs(32'd0, 32'd0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++)
            check({nm(d), "_half_valid_busy"}, 64'(bz[d]), 64'd0);
        repeat (40) @(negedge clk);

        // Second pair while busy is dropped.
        issue(32'd1000, 32'd10, 1'b1);
        repeat (5) @(negedge clk);
        issue(32'd77, 32'd7, 1'b0);
        repeat (40) @(negedge clk);

        // Back-to-back: next pair lands in the tvalid cycle.
        issue(32'd200, 32'd9, 1'b1);
        repeat (33) @(negedge clk);
        for (int d = 0; d < 2; d++)
            check({nm(d), "_b2b_tvalid"}, 64'(tv[d]), 64'd1);
        issue(32'hFFFF_FF00, 32'd3, 1'b1);
        repeat (36) @(negedge clk);

        // Clock-enable stall mid-CALC and again while tvalid is high.
        issue(32'd123457, 32'd13, 1'b1);
        repeat (10) @(negedge clk);
        aclken = 1'b0;
        repeat (10) @(negedge clk);
        aclken = 1'b1;
        for (int i = 0; i < 100 && !tv[0]; i++)
            @(negedge clk);
        check("stall_tvalid_seen", 64'(tv[0]), 64'd1);
        aclken = 1'b0;
        repeat (10) @(negedge clk);
        for (int d = 0; d < 2; d++)
            check({nm(d), "_frozen_tvalid"}, 64'(tv[d]), 64'd1);
        aclken = 1'b1;
        repeat (5) @(negedge clk);

        // Reset in the middle of an operation discards it.
        issue(32'd50, 32'd5, 1'b1);
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check({nm(d), "_midrst_tvalid"}, 64'(tv[d]), 64'd0);
            check({nm(d), "_midrst_dout"}, dt[d], 64'd0);
            check({nm(d), "_midrst_busy"}, 64'(bz[d]), 64'd0);
        end
        repeat (40) @(negedge clk);
        run(32'd9, 32'd3);

        for (int i = 0; i < 200 && (sb_q[0].size() != 0 || sb_q[1].size() != 0); i++)
            @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check({nm(d), "_drain"}, 64'(sb_q[d].size()), 64'd0);
            check({nm(d), "_dout_hold"}, dt[d], {32'd3, 32'd0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Behavioural iterative radix-2 divider that implements the core's divider IP interface as the responder.
- Lets the Verilator build run divide instructions without the vendor IP.
- The core drives dividend and divisor over AXI-stream-style valid-only channels; after a fixed latency this block returns the quotient and remainder packed in one 64-bit result beat.
- Instantiated wherever the core expects the divider, under a simulation-only wrapper.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits.
- SIGNED, 1, 1 = two's-complement division (truncate toward zero); 0 = unsigned.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-low.
- aclken  input  1  clock enable; when low, all state, counters and outputs are frozen.
- s_axis_divisor_tdata  input  WIDTH  divisor operand.
- s_axis_divisor_tvalid  input  1  divisor valid.
- s_axis_dividend_tdata  input  WIDTH  dividend operand.
- s_axis_dividend_tvalid  input  1  dividend valid.
- m_axis_dout_tdata  output  2*WIDTH  result: [2W-1:W] = quotient, [W-1:0] = remainder.
- m_axis_dout_tvalid  output  1  one-cycle result strobe.
- busy  output  1  high while an operation is in flight; inputs are ignored while high.

Behaviour:
- Reset (rst == 0 at an edge, regardless of aclken): state IDLE, m_axis_dout_tvalid = 0, m_axis_dout_tdata = 0, busy = 0, counter = 0. An operation in flight is discarded and no result strobe is produced.
- Accept condition: state IDLE, aclken = 1, and both tvalid inputs = 1 in the same cycle. Both operands are latched at that edge.
- One valid without the other: ignored. There is no per-channel buffering.
- Inputs presented while busy: ignored and not queued.
- State IDLE:
  - On accept, go to CALC and set busy = 1.
  - Latch the sign flags: quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend); both forced to 0 when SIGNED = 0.
  - Latch the operand magnitudes: |x| when SIGNED = 1, raw otherwise. |0x80000000| is taken as unsigned 2^31.
  - Set the counter to WIDTH.
- State CALC: one restoring shift-subtract step per enabled cycle. Remainder accumulator is WIDTH+1 bits. Quotient bit = 1 when the trial subtraction is non-negative. Counter decrements; after WIDTH steps go to FIX.
- State FIX (one enabled cycle):
  - Apply the latched signs: negate the quotient if its sign flag is set; negate the remainder if its sign flag is set.
  - Divide-by-zero override: if the divisor was 0, quotient = all ones and remainder = the original dividend. This matches RISC-V DIV/DIVU/REM/REMU.
  - Signed overflow (min / -1): quotient = 0x80000000, remainder = 0. This falls out of the magnitude arithmetic and needs no special case.
  - Load m_axis_dout_tdata, assert m_axis_dout_tvalid, return to IDLE, set busy = 0.
- m_axis_dout_tvalid is high for exactly one enabled cycle, then cleared.
- m_axis_dout_tdata holds its value until the next result is loaded.
- Latency is fixed at WIDTH+2 enabled edges from the accept edge to the edge that raises tvalid: 34 for WIDTH = 32. Zero divisor does not shorten it.
- Back-to-back operation: a new accept is legal in the same cycle that tvalid is high, since the block is already in IDLE. Minimum issue interval is WIDTH+2 enabled cycles.
- aclken low in any state freezes state, counter, accumulator and both outputs. A high tvalid stays high until the next enabled edge.

Test Plan:
- Unsigned basic: SIGNED=0, dividend=100, divisor=7, both valid for 1 cycle -> busy for 34 cycles, then one tvalid pulse with dout=0x0000000E_00000002.
- Signed truncation: SIGNED=1, -7/2 -> dout=0xFFFFFFFD_FFFFFFFF; 7/-2 -> 0xFFFFFFFD_00000001; -7/-2 -> 0x00000003_FFFFFFFF.
- Corner cases:
  - 5/0 -> 0xFFFFFFFF_00000005, still at 34-cycle latency.
  - Signed 0x80000000 / 0xFFFFFFFF -> 0x80000000_00000000.
  - Unsigned 0xFFFFFFFF/1 -> 0xFFFFFFFF_00000000.
- Handshake:
  - Only dividend_tvalid high -> no operation started.
  - Second operand pair presented while busy -> ignored; only the first result is produced.
  - New pair issued in the tvalid cycle -> accepted, next result 34 cycles later.
- aclken stall: drop aclken for 10 cycles mid-CALC, and again while tvalid is high -> result arrives 10 cycles later per stall; tvalid stays high across the frozen cycles; dout is correct.
- Reset mid-operation: rst low for 1 cycle at step 15 -> tvalid, dout and busy read 0 the next cycle; no stale strobe; a following 9/3 returns 0x00000003_00000000.
